// File: rtl/tty_pkg.sv
// Shared constants and FSM state encoding for the terminal character writer.
package tty_pkg;

    localparam logic [7:0] ASCII_BS       = 8'h08;
    localparam logic [7:0] ASCII_LF       = 8'h0A;
    localparam logic [7:0] ASCII_FF       = 8'h0C;
    localparam logic [7:0] ASCII_CR       = 8'h0D;
    localparam logic [7:0] ASCII_SPACE    = 8'h20;
    localparam logic [7:0] ASCII_PRINT_LO = 8'h20;
    localparam logic [7:0] ASCII_PRINT_HI = 8'h7E;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR_LINE,
        CLEAR_SCREEN
    } tty_state_t;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= ASCII_PRINT_LO) && (b <= ASCII_PRINT_HI);
    endfunction

endpackage

// File: rtl/tty_char_writer.sv
// Byte-stream terminal front end: cursor tracking, control codes and
// line/screen clear sweeps driving the character buffer write port.
module tty_char_writer #(
    parameter int CHAR_HORZ_CNT = 16,
    parameter int CHAR_VERT_CNT = 2,
    parameter int CHAR_HORZ_W   = $clog2(CHAR_HORZ_CNT),
    parameter int CHAR_VERT_W   = $clog2(CHAR_VERT_CNT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    output logic                   in_ready,
    output logic [CHAR_HORZ_W-1:0] char_hpos,
    output logic [CHAR_VERT_W-1:0] char_vpos,
    output logic                   char_write_en,
    output logic [7:0]             char_symbol,
    output logic                   cursor_valid,
    output logic [CHAR_HORZ_W-1:0] cursor_hpos,
    output logic [CHAR_VERT_W-1:0] cursor_vpos
);
    import tty_pkg::*;

    localparam logic [CHAR_HORZ_W-1:0] H_LAST = CHAR_HORZ_W'(CHAR_HORZ_CNT - 1);
    localparam logic [CHAR_VERT_W-1:0] V_LAST = CHAR_VERT_W'(CHAR_VERT_CNT - 1);
    localparam logic [CHAR_HORZ_W-1:0] H_ONE  = CHAR_HORZ_W'(1);
    localparam logic [CHAR_VERT_W-1:0] V_ONE  = CHAR_VERT_W'(1);

    tty_state_t             state_q;
    logic [CHAR_HORZ_W-1:0] cur_h_q, sw_h_q, wr_h_q;
    logic [CHAR_VERT_W-1:0] cur_v_q, sw_v_q, wr_v_q;
    logic                   wr_en_q, idle_q;
    logic [7:0]             sym_q;

    logic                   take_d, h_last_d, v_last_d;
    logic                   sw_h_last_d, sw_v_last_d;
    logic [CHAR_VERT_W-1:0] row_d;

    always_comb begin
        take_d      = in_valid && idle_q;
        h_last_d    = (cur_h_q == H_LAST);
        v_last_d    = (cur_v_q == V_LAST);
        sw_h_last_d = (sw_h_q == H_LAST);
        sw_v_last_d = (sw_v_q == V_LAST);
        row_d       = v_last_d ? '0 : cur_v_q + V_ONE;
    end

    // idle_q lags the state by one edge so ready rises after the last sweep write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CLEAR_SCREEN;
            cur_h_q <= '0;
            cur_v_q <= '0;
            sw_h_q  <= '0;
            sw_v_q  <= '0;
            wr_h_q  <= '0;
            wr_v_q  <= '0;
            wr_en_q <= 1'b0;
            sym_q   <= 8'h00;
            idle_q  <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    idle_q <= 1'b1;
                    if (take_d) begin
                        unique case (1'b1)
                            is_printable(in_data): begin
                                wr_en_q <= 1'b1;
                                sym_q   <= in_data;
                                wr_h_q  <= cur_h_q;
                                wr_v_q  <= cur_v_q;
                                if (!h_last_d) begin
                                    cur_h_q <= cur_h_q + H_ONE;
                                end else begin
                                    cur_h_q <= '0;
                                    cur_v_q <= row_d;
                                    if (v_last_d) begin
                                        state_q <= CLEAR_LINE;
                                        sw_h_q  <= '0;
                                        sw_v_q  <= row_d;
                                        idle_q  <= 1'b0;
                                    end
                                end
                            end
                            (in_data == ASCII_CR): begin
                                cur_h_q <= '0;
                            end
                            (in_data == ASCII_LF): begin
                                cur_h_q <= '0;
                                cur_v_q <= row_d;
                                if (v_last_d) begin
                                    state_q <= CLEAR_LINE;
                                    sw_h_q  <= '0;
                                    sw_v_q  <= row_d;
                                    idle_q  <= 1'b0;
                                end
                            end
                            (in_data == ASCII_BS): begin
                                if (cur_h_q != '0) begin
                                    cur_h_q <= cur_h_q - H_ONE;
                                    wr_en_q <= 1'b1;
                                    sym_q   <= ASCII_SPACE;
                                    wr_h_q  <= cur_h_q - H_ONE;
                                    wr_v_q  <= cur_v_q;
                                end
                            end
                            // first cell of the screen clear goes out with the accept
                            (in_data == ASCII_FF): begin
                                cur_h_q <= '0;
                                cur_v_q <= '0;
                                wr_en_q <= 1'b1;
                                sym_q   <= ASCII_SPACE;
                                wr_h_q  <= '0;
                                wr_v_q  <= '0;
                                state_q <= CLEAR_SCREEN;
                                sw_h_q  <= H_ONE;
                                sw_v_q  <= '0;
                                idle_q  <= 1'b0;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                CLEAR_LINE: begin
                    idle_q  <= 1'b0;
                    wr_en_q <= 1'b1;
                    sym_q   <= ASCII_SPACE;
                    wr_h_q  <= sw_h_q;
                    wr_v_q  <= sw_v_q;
                    if (sw_h_last_d) begin
                        state_q <= IDLE;
                    end else begin
                        sw_h_q <= sw_h_q + H_ONE;
                    end
                end
                CLEAR_SCREEN: begin
                    idle_q  <= 1'b0;
                    wr_en_q <= 1'b1;
                    sym_q   <= ASCII_SPACE;
                    wr_h_q  <= sw_h_q;
                    wr_v_q  <= sw_v_q;
                    if (sw_h_last_d) begin
                        sw_h_q <= '0;
                        if (sw_v_last_d) begin
                            state_q <= IDLE;
                        end else begin
                            sw_v_q <= sw_v_q + V_ONE;
                        end
                    end else begin
                        sw_h_q <= sw_h_q + H_ONE;
                    end
                end
            endcase
        end
    end

    assign in_ready      = idle_q;
    assign cursor_valid  = idle_q;
    assign cursor_hpos   = cur_h_q;
    assign cursor_vpos   = cur_v_q;
    assign char_write_en = wr_en_q;
    assign char_symbol   = sym_q;
    assign char_hpos     = wr_h_q;
    assign char_vpos     = wr_v_q;

endmodule

// File: tb/tb_tty_char_writer.sv
// Scoreboard bench for tty_char_writer: expected writes queued by the
// stimulus, popped by a negedge monitor on every write strobe.
module tb_tty_char_writer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [3:0] char_hpos;
    logic [0:0] char_vpos;
    logic       char_write_en;
    logic [7:0] char_symbol;
    logic       cursor_valid;
    logic [3:0] cursor_hpos;
    logic [0:0] cursor_vpos;

    int n_cmp = 0;
    int n_err = 0;
    logic [12:0] sb[$];

    tty_char_writer #(
        .CHAR_HORZ_CNT(16),
        .CHAR_VERT_CNT(2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .char_hpos    (char_hpos),
        .char_vpos    (char_vpos),
        .char_write_en(char_write_en),
        .char_symbol  (char_symbol),
        .cursor_valid (cursor_valid),
        .cursor_hpos  (cursor_hpos),
        .cursor_vpos  (cursor_vpos)
    );

    always #5 clk = ~clk;

    // monitor: every write strobe must match the oldest expected write
    always @(negedge clk) begin
        if (!rst && char_write_en) begin
            logic [12:0] got, exp;
            got = {char_hpos, char_vpos, char_symbol};
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: got h=%0d v=%0d sym=%h, want no write",
                         char_hpos, char_vpos, char_symbol);
            end else begin
                exp = sb.pop_front();
                if (got !== exp) begin
                    n_err++;
                    $display("FAIL write: got h=%0d v=%0d sym=%h, want h=%0d v=%0d sym=%h",
                             got[12:9], got[8], got[7:0], exp[12:9], exp[8], exp[7:0]);
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic push(input int h, input int v, input logic [7:0] s);
        sb.push_back({4'(h), 1'(v), s});
    endtask

    task automatic push_row_clear(input int v);
        for (int i = 0; i < 16; i++) push(i, v, 8'h20);
    endtask

    task automatic push_screen_clear();
        for (int r = 0; r < 2; r++) push_row_clear(r);
    endtask

    // called at a negedge; returns at the negedge after the accepting edge
    task automatic send(input logic [7:0] b);
        int k;
        k = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: byte %h not accepted, want accept", b);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic wait_ready(output int cyc);
        cyc = 0;
        while (!in_ready && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic chk_cursor(input string nm, input int h, input int v);
        chk({nm, "_h"}, int'(cursor_hpos), h);
        chk({nm, "_v"}, int'(cursor_vpos), v);
    endtask

    initial begin
        int cyc;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_write_en", int'(char_write_en), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_cursor_valid", int'(cursor_valid), 0);
        chk("rst_symbol", int'(char_symbol), 0);
        chk("rst_hpos", int'(char_hpos), 0);
        chk_cursor("rst_cursor", 0, 0);

        // power-on clear
        push_screen_clear();
        rst = 1'b0;
        wait_ready(cyc);
        chk("boot_clear_cycles", cyc, 33);
        chk("boot_cursor_valid", int'(cursor_valid), 1);
        chk_cursor("boot_cursor", 0, 0);
        chk("boot_sb_empty", sb.size(), 0);

        // back-to-back printable
        push(0, 0, 8'h41);
        push(1, 0, 8'h42);
        send(8'h41);
        send(8'h42);
        chk("ab_no_bubble", int'(in_ready), 1);
        chk_cursor("ab_cursor", 2, 0);

        // walk to (15,1), then wrap with 'Z'
        send(8'h0A);
        for (int i = 0; i < 15; i++) begin
            push(i, 1, 8'h61 + 8'(i));
            send(8'h61 + 8'(i));
        end
        chk_cursor("pre_wrap_cursor", 15, 1);
        push(15, 1, 8'h5A);
        push_row_clear(0);
        send(8'h5A);
        chk("wrap_busy", int'(in_ready), 0);
        wait_ready(cyc);
        chk("wrap_clear_cycles", cyc, 17);
        chk_cursor("wrap_cursor", 0, 0);
        chk("wrap_sb_empty", sb.size(), 0);

        // backspace
        send(8'h0A);
        push(0, 1, 8'h78);
        push(1, 1, 8'h79);
        push(2, 1, 8'h7A);
        send(8'h78);
        send(8'h79);
        send(8'h7A);
        chk_cursor("pre_bs_cursor", 3, 1);
        push(2, 1, 8'h20);
        send(8'h08);
        chk_cursor("bs_cursor", 2, 1);
        send(8'h0D);
        send(8'h08);
        repeat (2) @(negedge clk);
        chk_cursor("bs_col0_cursor", 0, 1);
        chk("bs_sb_empty", sb.size(), 0);

        // LF on the last row wraps and clears row 0
        push_row_clear(0);
        send(8'h0A);
        wait_ready(cyc);
        chk("lf_wrap_cycles", cyc, 17);
        chk_cursor("lf_wrap_cursor", 0, 0);
        for (int i = 0; i < 5; i++) begin
            push(i, 0, 8'h68);
            send(8'h68);
        end
        chk_cursor("pre_ctl_cursor", 5, 0);
        send(8'h0D);
        send(8'h0A);
        send(8'h07);
        send(8'h9F);
        repeat (2) @(negedge clk);
        chk_cursor("ctl_cursor", 0, 1);
        chk("ctl_sb_empty", sb.size(), 0);

        // form feed interrupted by reset after 10 clear writes
        for (int i = 0; i < 10; i++) push(i, 0, 8'h20);
        send(8'h0C);
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_write_en", int'(char_write_en), 0);
        chk("rst_async_in_ready", int'(in_ready), 0);
        chk("ff_partial_sb_empty", sb.size(), 0);
        @(negedge clk);
        push_screen_clear();
        rst = 1'b0;
        wait_ready(cyc);
        chk("reclear_cycles", cyc, 33);
        chk_cursor("reclear_cursor", 0, 0);
        chk("reclear_sb_empty", sb.size(), 0);

        repeat (3) @(negedge clk);
        chk("final_sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
